// File: rtl/spypath_delay_meter.sv
`timescale 1ns/1ps
// spypath_delay_meter: launch/capture controller timing edge arrival through one spypath chain.
// Optional feature macro SPYPATH_MINMAX_EN enables delayMin/delayMax tracking (otherwise both read 0).
module spypath_delay_meter #(
  parameter int CNT_W       = 16,
  parameter int TRIALS_W    = 8,
  parameter int TIMEOUT_CYC = 1023,
  parameter int SETTLE_CYC  = 8,
  parameter int INVERT      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [TRIALS_W-1:0]       numTrials,
  output logic                      pathInput,
  input  logic                      pathResult,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic [TRIALS_W-1:0]       trialCount,
  output logic [CNT_W+TRIALS_W-1:0] delaySum,
  output logic [CNT_W-1:0]          delayMin,
  output logic [CNT_W-1:0]          delayMax
);

  localparam int   SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic INV   = (INVERT != 0);

  typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, WAIT, RECORD, FIN} state_t;

  state_t              state;
  logic [1:0]          resPipe;
  logic                resSync;
  logic                expected;
  logic [CNT_W-1:0]    cycCnt;
  logic [SET_W-1:0]    settleCnt;
  logic [TRIALS_W-1:0] numTrialsQ;
  logic [TRIALS_W:0]   trialNext;
  logic                startAcc;
  logic                recordEv;

  assign resSync   = resPipe[1];
  assign expected  = pathInput ^ INV;
  assign trialNext = {1'b0, trialCount} + (TRIALS_W+1)'(1);
  assign startAcc  = (state == IDLE) && start;
  assign recordEv  = (state == RECORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) resPipe <= '0;
    else     resPipe <= {resPipe[0], pathResult};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pathInput  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      trialCount <= '0;
      delaySum   <= '0;
      cycCnt     <= '0;
      settleCnt  <= '0;
      numTrialsQ <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            numTrialsQ <= numTrials;
            trialCount <= '0;
            delaySum   <= '0;
            timeout    <= 1'b0;
            busy       <= 1'b1;
            settleCnt  <= '0;
            state      <= (numTrials == '0) ? FIN : SETTLE;
          end
        end
        SETTLE: begin
          if (resSync == expected) begin
            if (settleCnt == SET_W'(SETTLE_CYC - 1)) begin
              settleCnt <= '0;
              state     <= LAUNCH;
            end else begin
              settleCnt <= settleCnt + SET_W'(1);
            end
          end else begin
            settleCnt <= '0;
          end
        end
        LAUNCH: begin
          pathInput <= ~pathInput;
          cycCnt    <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (resSync == expected) begin
            state <= RECORD;
          end else if (cycCnt == CNT_W'(TIMEOUT_CYC)) begin
            // Timed-out trial is abandoned without touching the accumulators.
            timeout <= 1'b1;
            state   <= FIN;
          end else begin
            cycCnt <= cycCnt + CNT_W'(1);
          end
        end
        RECORD: begin
          delaySum   <= delaySum + (CNT_W+TRIALS_W)'(cycCnt);
          trialCount <= trialNext[TRIALS_W-1:0];
          settleCnt  <= '0;
          state      <= (trialNext == {1'b0, numTrialsQ}) ? FIN : SETTLE;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPYPATH_MINMAX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delayMin <= '0;
      delayMax <= '0;
    end else if (startAcc) begin
      delayMin <= '1;
      delayMax <= '0;
    end else if (recordEv) begin
      if (cycCnt < delayMin) delayMin <= cycCnt;
      if (cycCnt > delayMax) delayMax <= cycCnt;
    end
  end
`else
  logic unusedMinMax;
  assign unusedMinMax = startAcc ^ recordEv;
  assign delayMin     = '0;
  assign delayMax     = '0;
`endif

endmodule

// File: tb/tb_spypath_delay_meter.sv
`timescale 1ns/1ps
// Self-checking bench for spypath_delay_meter: chain modelled as a D-edge shift register.
module tb_spypath_delay_meter;

  localparam int TIMEOUT_CYC = 1023;
  localparam int SETTLE_CYC  = 8;
`ifdef SPYPATH_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  numTrials = '0;
  logic        pathInput, pathResult, busy, done, timeout;
  logic [7:0]  trialCount;
  logic [23:0] delaySum;
  logic [15:0] delayMin, delayMax;

  int tests = 0;
  int fails = 0;

  spypath_delay_meter #(.CNT_W(16), .TRIALS_W(8), .TIMEOUT_CYC(TIMEOUT_CYC),
                        .SETTLE_CYC(SETTLE_CYC), .INVERT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .numTrials(numTrials),
    .pathInput(pathInput), .pathResult(pathResult), .busy(busy), .done(done),
    .timeout(timeout), .trialCount(trialCount), .delaySum(delaySum),
    .delayMin(delayMin), .delayMax(delayMax));

  always #5 clk = ~clk;

  // Chain model: per-launch delay D taken from dTab, indexed by absolute launch number.
  logic [15:0] sr = '0;
  int  dTab [64];
  int  curD = 1;
  int  launches = 0;
  bit  stuck = 1'b0;

  always @(posedge clk) sr <= {sr[14:0], pathInput};
  always @(pathInput) begin
    curD = dTab[launches % 64];
    launches++;
  end
  assign pathResult = stuck ? 1'b0 : sr[4'(curD - 1)];

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic fillConst(input int d);
    for (int i = 0; i < 64; i++) dTab[i] = d;
  endtask

  task automatic pulseStart(input int n);
    @(posedge clk); #1;
    start = 1'b1; numTrials = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int bound, output bit got, output int cyc);
    got = 1'b0; cyc = 0;
    while (!got && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    tests++;
    if ({busy, done, timeout, pathInput, trialCount, delaySum, delayMin, delayMax} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got busy=%0b done=%0b to=%0b pi=%0b tc=%0d sum=%0d min=%0d max=%0d want all 0",
               busy, done, timeout, pathInput, trialCount, delaySum, delayMin, delayMax);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit got; int cyc; int base; logic pi0;
    fillConst(5);
    base = launches; pi0 = pathInput;
    pulseStart(4);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %0b want 1", busy); end
    waitDone(500, got, cyc);
    tests++;
    if (!got) begin fails++; $display("FAIL basic_done got none want pulse within 500"); end
    tests++;
    if (delaySum !== 24'd28) begin fails++; $display("FAIL basic_sum got %0d want 28", delaySum); end
    tests++;
    if (trialCount !== 8'd4) begin fails++; $display("FAIL basic_count got %0d want 4", trialCount); end
    tests++;
    if (timeout !== 1'b0) begin fails++; $display("FAIL basic_timeout got %0b want 0", timeout); end
    tests++;
    if (delayMin !== (MM ? 16'd7 : 16'd0) || delayMax !== (MM ? 16'd7 : 16'd0)) begin
      fails++; $display("FAIL basic_minmax got %0d/%0d want %0d/%0d", delayMin, delayMax, MM ? 7 : 0, MM ? 7 : 0);
    end
    tests++;
    if (launches - base != 4 || pathInput !== pi0) begin
      fails++; $display("FAIL basic_launches got %0d pi=%0b want 4 pi=%0b", launches - base, pathInput, pi0);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_after got done=%0b busy=%0b want 0/0", done, busy);
    end
  endtask

  task automatic test_alternating();
    bit got; int cyc; int base;
    base = launches;
    for (int i = 0; i < 64; i++) dTab[(base + i) % 64] = (i % 2 == 0) ? 3 : 6;
    pulseStart(2);
    waitDone(500, got, cyc);
    tests++;
    if (!got || delaySum !== 24'd13) begin
      fails++; $display("FAIL alt_sum got done=%0b sum=%0d want done=1 sum=13", got, delaySum);
    end
    tests++;
    if (delayMin !== (MM ? 16'd5 : 16'd0) || delayMax !== (MM ? 16'd8 : 16'd0)) begin
      fails++; $display("FAIL alt_minmax got %0d/%0d want %0d/%0d", delayMin, delayMax, MM ? 5 : 0, MM ? 8 : 0);
    end
  endtask

  task automatic test_random();
    bit got; int cyc; int base; int n; int s; int mn; int mx; int d;
    for (int r = 0; r < 4; r++) begin
      base = launches;
      n = $urandom_range(1, 6);
      for (int i = 0; i < 64; i++) dTab[i] = $urandom_range(1, 8);
      s = 0; mn = 65535; mx = 0;
      for (int i = 0; i < n; i++) begin
        d = dTab[(base + i) % 64] + 2;
        s += d;
        if (d < mn) mn = d;
        if (d > mx) mx = d;
      end
      pulseStart(n);
      waitDone(1000, got, cyc);
      tests++;
      if (!got || delaySum !== 24'(s) || trialCount !== 8'(n) || timeout !== 1'b0) begin
        fails++;
        $display("FAIL rand%0d_result got done=%0b sum=%0d tc=%0d to=%0b want 1 %0d %0d 0",
                 r, got, delaySum, trialCount, timeout, s, n);
      end
      tests++;
      if (delayMin !== 16'(MM ? mn : 0) || delayMax !== 16'(MM ? mx : 0)) begin
        fails++; $display("FAIL rand%0d_minmax got %0d/%0d want %0d/%0d", r, delayMin, delayMax, MM ? mn : 0, MM ? mx : 0);
      end
    end
  endtask

  task automatic test_timeout();
    bit got; int cyc;
    stuck = 1'b1;
    doReset();
    pulseStart(3);
    waitDone(1500, got, cyc);
    tests++;
    if (!got || timeout !== 1'b1) begin
      fails++; $display("FAIL to_flag got done=%0b timeout=%0b want 1/1", got, timeout);
    end
    tests++;
    if (trialCount !== 8'd0 || delaySum !== 24'd0 || pathInput !== 1'b1) begin
      fails++; $display("FAIL to_results got tc=%0d sum=%0d pi=%0b want 0 0 1", trialCount, delaySum, pathInput);
    end
    tests++;
    if (cyc < TIMEOUT_CYC || cyc > TIMEOUT_CYC + SETTLE_CYC + 4) begin
      fails++; $display("FAIL to_latency got %0d cycles want %0d..%0d", cyc, TIMEOUT_CYC, TIMEOUT_CYC + SETTLE_CYC + 4);
    end
    tests++;
    if (delayMin !== (MM ? 16'hFFFF : 16'd0) || delayMax !== 16'd0) begin
      fails++; $display("FAIL to_minmax got %0d/%0d want %0d/0", delayMin, delayMax, MM ? 65535 : 0);
    end
    stuck = 1'b0;
  endtask

  task automatic test_zero_trials();
    pulseStart(0);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL zero_first got busy=%0b done=%0b want 1/0", busy, done);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL zero_done got done=%0b busy=%0b want 1/0", done, busy);
    end
    tests++;
    if (trialCount !== 8'd0 || delaySum !== 24'd0 || timeout !== 1'b0) begin
      fails++; $display("FAIL zero_results got tc=%0d sum=%0d to=%0b want 0 0 0", trialCount, delaySum, timeout);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL zero_after got done=%0b busy=%0b want 0/0", done, busy);
    end
  endtask

  task automatic test_reset_midrun();
    bit got; int cyc; int base; int spurious;
    fillConst(5);
    base = launches;
    pulseStart(4);
    cyc = 0;
    while (launches - base < 2 && cyc < 300) begin @(posedge clk); #1; cyc++; end
    tests++;
    if (launches - base < 2) begin fails++; $display("FAIL mid_reach got %0d launches want 2", launches - base); end
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, timeout, pathInput, trialCount, delaySum, delayMin, delayMax} !== '0) begin
      fails++;
      $display("FAIL mid_reset got busy=%0b done=%0b to=%0b pi=%0b tc=%0d sum=%0d min=%0d max=%0d want all 0",
               busy, done, timeout, pathInput, trialCount, delaySum, delayMin, delayMax);
    end
    @(posedge clk); #1; rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (done || busy) spurious++; end
    tests++;
    if (spurious != 0) begin fails++; $display("FAIL mid_nodone got %0d active cycles want 0", spurious); end
    pulseStart(2);
    waitDone(500, got, cyc);
    tests++;
    if (!got || delaySum !== 24'd14 || trialCount !== 8'd2) begin
      fails++; $display("FAIL mid_rerun got done=%0b sum=%0d tc=%0d want 1 14 2", got, delaySum, trialCount);
    end
  endtask

  task automatic test_back_to_back();
    int doneCnt; int cyc; int spurious;
    fillConst(5);
    pulseStart(3);
    doneCnt = 0; cyc = 0;
    // Keep start high (with a different trial count) every cycle busy is seen, FIN included.
    while (doneCnt == 0 && cyc < 500) begin
      if (busy) begin start = 1'b1; numTrials = 8'd7; end
      else      start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (done) doneCnt++;
    end
    start = 1'b0;
    tests++;
    if (doneCnt != 1 || delaySum !== 24'd21 || trialCount !== 8'd3) begin
      fails++; $display("FAIL b2b_result got done=%0d sum=%0d tc=%0d want 1 21 3", doneCnt, delaySum, trialCount);
    end
    spurious = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (done || busy) spurious++; end
    tests++;
    if (spurious != 0 || delaySum !== 24'd21) begin
      fails++; $display("FAIL b2b_ignored got %0d active cycles sum=%0d want 0 21", spurious, delaySum);
    end
  endtask

  initial begin
    fillConst(1);
    test_reset();
    test_basic();
    test_alternating();
    test_random();
    test_timeout();
    test_zero_trials();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
